fp_add_control: RTL

Sequencing controller for the single-precision `floatingOperation` datapath. It accepts a start request, samples the exponent difference produced by the datapath's small ALU, and drives the align-mux select and shift amount. It then steps the datapath through add, normalize and round, re-entering normalization until the datapath reports a normalized rounded result, and finally pulses `done`. It sits between the instruction-decode stage (start/operation) and the `floatingOperation` datapath.

---
 rtl/fp_ctrl_pkg.sv | 23 ++
 rtl/shift_qtt_calc.sv | 23 ++
 rtl/fp_add_control.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the fp_add_control sequencer.
// Optional pass-limit logic in the top is enabled by FP_CTRL_TIMEOUT_EN.
package fp_ctrl_pkg;

  localparam int FRACTION_W = 23;
  localparam int EXPONENT_W = 8;
  localparam int SHIFT_SAT  = FRACTION_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

endpackage

// File: rtl/shift_qtt_calc.sv
// Turns the small-ALU exponent difference into an alignment shift amount:
// absolute value of the difference, saturated at one past the fraction width.
module shift_qtt_calc #(
  parameter int FRACTION = 23,
  parameter int EXPONENT = 8
) (
  input  logic [EXPONENT-1:0] exp_diff,
  input  logic                exp_borrow,
  output logic [EXPONENT-1:0] shift_qtt
);

  localparam logic [EXPONENT:0] SAT  = (EXPONENT+1)'(FRACTION + 1);
  localparam logic [EXPONENT:0] FULL = {1'b1, {EXPONENT{1'b0}}};

  logic [EXPONENT:0] mag;

  // One extra bit so a zero difference with borrow reads as 2^EXPONENT.
  always_comb begin
    mag       = exp_borrow ? (FULL - {1'b0, exp_diff}) : {1'b0, exp_diff};
    shift_qtt = (mag > SAT) ? SAT[EXPONENT-1:0] : mag[EXPONENT-1:0];
  end

endmodule

// File: rtl/fp_add_control.sv
// Sequencer for the floatingOperation datapath: align, add, normalize/round loop, done.
// Define FP_CTRL_TIMEOUT_EN to bound the normalize/round loop at MAX_PASSES.
module fp_add_control
  import fp_ctrl_pkg::*;
#(
  parameter int FRACTION = FRACTION_W,
  parameter int EXPONENT = EXPONENT_W
`ifdef FP_CTRL_TIMEOUT_EN
  ,
  parameter int MAX_PASSES = 2
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          operation,
  input  logic [EXPONENT-1:0] exp_diff,
  input  logic                exp_borrow,
  input  logic                norm_ok,
  output logic                smaller_exp_src,
  output logic [EXPONENT-1:0] shift_right_qtt,
  output logic                normalization_src,
  output logic [1:0]          alu_op,
  output logic                load_sum,
  output logic                load_norm,
  output logic                load_round,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t state, state_next;
  logic err_next;
  logic [EXPONENT-1:0] shift_calc;
  logic is_mul;

`ifdef FP_CTRL_TIMEOUT_EN
  localparam int PW = (MAX_PASSES > 1) ? $clog2(MAX_PASSES + 1) : 1;
  localparam logic [PW-1:0] PASS_LAST = PW'(MAX_PASSES - 1);
  logic [PW-1:0] pass_cnt;
`endif

  shift_qtt_calc #(
    .FRACTION (FRACTION),
    .EXPONENT (EXPONENT)
  ) u_shift_calc (
    .exp_diff   (exp_diff),
    .exp_borrow (exp_borrow),
    .shift_qtt  (shift_calc)
  );

  assign is_mul = (alu_op == OP_MUL);

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign load_sum   = (state == ADD);
  assign load_norm  = (state == NORM);
  assign load_round = (state == ROUND);

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (operation == OP_RSV) begin
            state_next = DONE;
            err_next   = 1'b1;
          end else begin
            state_next = ALIGN;
          end
        end
      end
      ALIGN: state_next = ADD;
      ADD:   state_next = NORM;
      NORM:  state_next = ROUND;
      ROUND: begin
        if (norm_ok) begin
          state_next = DONE;
        end else begin
`ifdef FP_CTRL_TIMEOUT_EN
          if (pass_cnt == PASS_LAST) begin
            state_next = DONE;
            err_next   = 1'b1;
          end else begin
            state_next = NORM;
          end
`else
          state_next = NORM;
`endif
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // err is registered on entry to DONE so it lines up with the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      err               <= 1'b0;
      alu_op            <= 2'b00;
      smaller_exp_src   <= 1'b0;
      shift_right_qtt   <= '0;
      normalization_src <= 1'b0;
    end else begin
      state <= state_next;
      err   <= err_next;
      if (state == IDLE && start) begin
        alu_op <= operation;
      end
      if (state == ALIGN) begin
        smaller_exp_src <= is_mul ? 1'b0 : exp_borrow;
        shift_right_qtt <= is_mul ? '0 : shift_calc;
      end
      if (state == ROUND && !norm_ok) begin
        normalization_src <= 1'b1;
      end else if (state == IDLE) begin
        normalization_src <= 1'b0;
      end
    end
  end

`ifdef FP_CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt <= '0;
    end else if (state == IDLE) begin
      pass_cnt <= '0;
    end else if (state == ROUND && !norm_ok) begin
      pass_cnt <= pass_cnt + 1'b1;
    end
  end
`endif

endmodule
